// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg
// Shared types for the sequential ALU: the opcode encoding seen on the
// i_op port and the state encoding of the control FSM.
// No ports; imported with "import seq_alu_pkg::*;".

package seq_alu_pkg;

  // Opcode encoding as presented on i_op.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_OR  = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  // Control FSM states. MUL is only ever entered when the multiplier is built.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul
// Shift-add unsigned multiplier, one partial product per clock, LSB of the
// multiplier first. Only instantiated when SEQ_ALU_MUL_EN is defined.
// Ports:
//   i_clk      rising-edge clock
//   i_rstn     synchronous active-low reset
//   i_start    load operands and begin a WIDTH-cycle multiply
//   i_a, i_b   unsigned operands (sampled on i_start)
//   o_done     high in the final iteration; o_product is complete then
//   o_product  2*WIDTH-bit product including the current partial product

module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               r_busy;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;

  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_nextAcc;

  // The product is exposed including this cycle's partial product so the
  // caller can latch the full result on the same edge the last step retires.
  assign w_partial = r_mplier[0] ? r_mcand : '0;
  assign w_nextAcc = r_acc + w_partial;
  assign o_done    = r_busy && (r_count == LAST);
  assign o_product = w_nextAcc;

  // Iteration datapath: shift the multiplicand up and the multiplier down
  // each cycle, accumulating whenever the multiplier LSB is set.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_nextAcc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu
// Clocked ALU with valid/ready handshakes on both sides. Single-cycle ops
// (ADD, SUB, AND, XOR, OR, SHL, SHR) go straight to DONE; MUL runs through
// the shift-add multiplier for WIDTH cycles when SEQ_ALU_MUL_EN is defined,
// otherwise op=111 is reported as illegal with a zero result.
// Configuration macro: SEQ_ALU_MUL_EN (multiplier built when defined).
// Ports:
//   i_clk, i_rstn         clock, synchronous active-low reset
//   i_in_valid/o_in_ready input handshake (ready only in IDLE, out of reset)
//   i_op, i_a, i_b        opcode and unsigned operands, captured on accept
//   o_out_valid/i_out_ready output handshake
//   o_result              2*WIDTH-bit zero-extended result
//   o_zero, o_ovf, o_illegal  status flags held with the result

module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_zero,
  output logic               o_ovf,
  output logic               o_illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_IMPL = 1'b1;
`else
  localparam bit MUL_IMPL = 1'b0;
`endif

  state_e             r_state;
  logic               r_outValid;
  logic [2*WIDTH-1:0] r_result;
  logic               r_zero;
  logic               r_ovf;
  logic               r_illegal;

  logic               w_accept;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [SHW-1:0]     w_sh;
  logic [2*WIDTH-1:0] w_aExt;
  logic [2*WIDTH-1:0] w_aluResult;
  logic               w_aluOvf;
  logic               w_aluIllegal;

  // in_ready is gated by reset directly so it drops in the same cycle rstn falls.
  assign o_in_ready  = (r_state == IDLE) && i_rstn;
  assign w_accept    = i_in_valid && o_in_ready;

  assign o_out_valid = r_outValid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_ovf       = r_ovf;
  assign o_illegal   = r_illegal;

  // Extra top bit of the sum is the carry; of the difference it is the borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SHW-1:0];
  assign w_aExt = {{WIDTH{1'b0}}, i_a};

  // Single-cycle datapath evaluated on the live inputs; its output is only
  // captured on the accept edge, so later input changes never reach o_result.
  always_comb begin
    w_aluResult  = '0;
    w_aluOvf     = 1'b0;
    w_aluIllegal = 1'b0;
    case (op_e'(i_op))
      OP_ADD: begin
        w_aluResult = {{(WIDTH-1){1'b0}}, w_sum};
        w_aluOvf    = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        w_aluResult = {{(WIDTH-1){1'b0}}, w_diff};
        w_aluOvf    = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      OP_AND: w_aluResult = {{WIDTH{1'b0}}, i_a & i_b};
      OP_XOR: w_aluResult = {{WIDTH{1'b0}}, i_a ^ i_b};
      OP_OR:  w_aluResult = {{WIDTH{1'b0}}, i_a | i_b};
      OP_SHL: w_aluResult = w_aExt << w_sh;
      OP_SHR: w_aluResult = {{WIDTH{1'b0}}, i_a >> w_sh};
      OP_MUL: w_aluIllegal = ~MUL_IMPL;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic               w_goMul;
  logic               w_mulStart;
  logic               w_mulDone;
  logic [2*WIDTH-1:0] w_mulProduct;

  assign w_goMul    = (op_e'(i_op) == OP_MUL);
  assign w_mulStart = w_accept && w_goMul;

  seq_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_start  (w_mulStart),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_done   (w_mulDone),
    .o_product(w_mulProduct)
  );
`endif

  // Control FSM. Result and flags are written only on entry to DONE and are
  // left untouched until the consumer takes them, which gives backpressure
  // stability for free. Requests arriving outside IDLE never see in_ready.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
`ifdef SEQ_ALU_MUL_EN
            if (w_goMul) r_state <= MUL; else
`endif
            begin
              r_state    <= DONE;
              r_outValid <= 1'b1;
              r_result   <= w_aluResult;
              r_zero     <= (w_aluResult == '0);
              r_ovf      <= w_aluOvf;
              r_illegal  <= w_aluIllegal;
            end
          end
        end
`ifdef SEQ_ALU_MUL_EN
        MUL: begin
          if (w_mulDone) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
            r_result   <= w_mulProduct;
            r_zero     <= (w_mulProduct == '0);
            r_ovf      <= 1'b0;
            r_illegal  <= 1'b0;
          end
        end
`endif
        DONE: begin
          if (i_out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
// Scoreboard bench for seq_alu (WIDTH=8). Expected results are pushed when an
// operation is accepted and popped when out_valid rises; latency, result and
// flags are compared, and held values are re-checked every cycle while the
// output is backpressured. Adapts to SEQ_ALU_MUL_EN.

module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 8;

`ifdef SEQ_ALU_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           z;
    logic           o;
    logic           i;
  } exp_t;

  typedef struct {
    exp_t e;
    int   lat;
    int   acc;
  } sb_t;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] r;
    logic           z;
    logic           o;
    logic           i;
    int             lat;
  } vec_t;

  logic           clk = 1'b0;
  logic           i_rstn;
  logic           i_in_valid;
  logic           o_in_ready;
  logic [2:0]     i_op;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic           o_out_valid;
  logic           i_out_ready;
  logic [2*W-1:0] o_result;
  logic           o_zero;
  logic           o_ovf;
  logic           o_illegal;

  int   checkCount = 0;
  int   errorCount = 0;
  int   cycleCount = 0;
  int   lastAccept = 0;
  sb_t  sb[$];
  sb_t  cur;
  bit   curLoaded = 1'b0;
  logic prevValid = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rstn     (i_rstn),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_op       (i_op),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_ovf      (o_ovf),
    .o_illegal  (o_illegal)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard stop in case something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model for one operation.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] low;
    int           sh;
    e   = '0;
    sh  = int'(b) % W;
    case (op)
      3'd0: begin
        e.res = {{W{1'b0}}, a} + {{W{1'b0}}, b};
        low   = a + b;
        e.o   = (a[W-1] == b[W-1]) && (low[W-1] != a[W-1]);
      end
      3'd1: begin
        low      = a - b;
        e.res    = {{W{1'b0}}, low};
        e.res[W] = (a < b);
        e.o      = (a[W-1] != b[W-1]) && (low[W-1] != a[W-1]);
      end
      3'd2: e.res = {{W{1'b0}}, a & b};
      3'd3: e.res = {{W{1'b0}}, a ^ b};
      3'd4: e.res = {{W{1'b0}}, a | b};
      3'd5: e.res = {{W{1'b0}}, a} << sh;
      3'd6: e.res = {{W{1'b0}}, a >> sh};
      default: begin
        if (MULEN) e.res = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        else       e.i   = 1'b1;
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Waits for in_ready, presents one request for exactly one accept edge and
  // pushes its expectation; operands are scrambled after the accept.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input exp_t e, input int lat);
    int  waitCycles = 0;
    sb_t item;
    @(negedge clk);
    while (o_in_ready !== 1'b1 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (o_in_ready !== 1'b1) begin
      checkOutput("inReadyTimeout", {31'd0, o_in_ready}, 32'd1);
      return;
    end
    i_in_valid = 1'b1;
    i_op       = op;
    i_a        = a;
    i_b        = b;
    item.e     = e;
    item.lat   = lat;
    item.acc   = cycleCount;
    lastAccept = cycleCount;
    sb.push_back(item);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_op       = 3'($urandom);
    i_a        = W'($urandom);
    i_b        = W'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((sb.size() != 0 || o_out_valid !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainPending", sb.size(), 32'd0);
  endtask

  // Output monitor: pop and compare on each rising out_valid, and verify the
  // held result/flags stay frozen for every further cycle out_valid is high.
  always @(negedge clk) begin
    if (o_out_valid === 1'b1 && prevValid !== 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedValid", 32'd1, 32'd0);
        curLoaded = 1'b0;
      end else begin
        cur       = sb.pop_front();
        curLoaded = 1'b1;
        checkOutput("latency", cycleCount - cur.acc, cur.lat);
        checkOutput("result", {16'd0, o_result}, {16'd0, cur.e.res});
        checkOutput("zero", {31'd0, o_zero}, {31'd0, cur.e.z});
        checkOutput("ovf", {31'd0, o_ovf}, {31'd0, cur.e.o});
        checkOutput("illegal", {31'd0, o_illegal}, {31'd0, cur.e.i});
      end
    end else if (o_out_valid === 1'b1 && curLoaded) begin
      checkOutput("holdStable", {13'd0, o_result, o_zero, o_ovf, o_illegal},
                  {13'd0, cur.e});
    end
    prevValid = o_out_valid;
  end

  initial begin
    vec_t       vecs[$];
    logic [2:0] rOp;
    logic [W-1:0] rA;
    logic [W-1:0] rB;
    int         acc1;
    int         highs;

    vecs.push_back('{OP_ADD, 8'hE3, 8'h82, 16'h0165, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_SUB, 8'h02, 8'h03, 16'h01FF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SUB, 8'h55, 8'h55, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_AND, 8'h71, 8'h2A, 16'h0020, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_XOR, 8'h71, 8'h2A, 16'h005B, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_OR,  8'h71, 8'h2A, 16'h007B, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SHL, 8'hE3, 8'h04, 16'h0E30, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SHL, 8'hFF, 8'hFF, 16'h7F80, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SHR, 8'hE3, 8'hF3, 16'h001C, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_ADD, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SUB, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b1, 1'b0, 1});
`ifdef SEQ_ALU_MUL_EN
    vecs.push_back('{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, W + 1});
    vecs.push_back('{OP_MUL, 8'h00, 8'h5A, 16'h0000, 1'b1, 1'b0, 1'b0, W + 1});
    vecs.push_back('{OP_MUL, 8'hA5, 8'h81, 16'h5325, 1'b0, 1'b0, 1'b0, W + 1});
`else
    vecs.push_back('{OP_MUL, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1});
`endif

    i_rstn      = 1'b0;
    i_in_valid  = 1'b0;
    i_op        = 3'd0;
    i_a         = '0;
    i_b         = '0;
    i_out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rstOutValid", {31'd0, o_out_valid}, 32'd0);
    checkOutput("rstResult", {16'd0, o_result}, 32'd0);
    checkOutput("rstFlags", {29'd0, o_zero, o_ovf, o_illegal}, 32'd0);
    checkOutput("rstInReady", {31'd0, o_in_ready}, 32'd0);
    i_rstn = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'd0, o_in_ready}, 32'd1);

    // Directed vectors, back to back.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].op, vecs[k].a, vecs[k].b,
                    '{vecs[k].r, vecs[k].z, vecs[k].o, vecs[k].i}, vecs[k].lat);
    end
    waitIdle();

    // Throughput: two single-cycle ops with out_ready held high.
    applyStimulus(OP_ADD, 8'h10, 8'h20, model(3'd0, 8'h10, 8'h20), 1);
    acc1 = lastAccept;
    applyStimulus(OP_XOR, 8'h0F, 8'hF0, model(3'd3, 8'h0F, 8'hF0), 1);
    checkOutput("throughput", lastAccept - acc1, 32'd2);
    waitIdle();

    // Random operations checked against the model.
    for (int k = 0; k < 24; k++) begin
      rOp = 3'($urandom_range(0, 7));
      rA  = W'($urandom);
      rB  = W'($urandom);
      applyStimulus(rOp, rA, rB, model(rOp, rA, rB),
                    (rOp == 3'd7 && MULEN) ? W + 1 : 1);
    end
    waitIdle();

    // Backpressure: result held, in_ready low, a stray request ignored.
    i_out_ready = 1'b0;
    applyStimulus(OP_OR, 8'h71, 8'h2A, model(3'd4, 8'h71, 8'h2A), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bpValid", {31'd0, o_out_valid}, 32'd1);
      checkOutput("bpInReady", {31'd0, o_in_ready}, 32'd0);
      i_in_valid = 1'b1;
      i_op       = OP_ADD;
      i_a        = 8'h01;
      i_b        = 8'h01;
    end
    i_in_valid = 1'b0;
    @(negedge clk);
    i_out_ready = 1'b1;
    highs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_out_valid === 1'b1) highs++;
    end
    checkOutput("strayIgnored", highs, 32'd0);
    checkOutput("bpReadyBack", {31'd0, o_in_ready}, 32'd1);

    // Reset in the middle of a MUL (or while its result is held).
    i_out_ready = 1'b0;
    applyStimulus(OP_MUL, 8'hFF, 8'hFF, model(3'd7, 8'hFF, 8'hFF), MULEN ? W + 1 : 1);
    repeat (2) @(negedge clk);
    i_rstn = 1'b0;
    #1;
    checkOutput("readyLowInReset", {31'd0, o_in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("abortOutValid", {31'd0, o_out_valid}, 32'd0);
    checkOutput("abortResult", {16'd0, o_result}, 32'd0);
    checkOutput("abortFlags", {29'd0, o_zero, o_ovf, o_illegal}, 32'd0);
    sb.delete();
    i_rstn      = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("abortReady", {31'd0, o_in_ready}, 32'd1);
    highs = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_out_valid === 1'b1) highs++;
    end
    checkOutput("abortNoPulse", highs, 32'd0);
    applyStimulus(OP_ADD, 8'h01, 8'h01, '{16'h0002, 1'b0, 1'b0, 1'b0}, 1);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
